// File: rtl/aes128_enc_round_ctrl_pkg.sv
// Shared AES-128 definitions: block type, controller states, RCON and the
// combinational round primitives used by the iterative encryptor.
package aes128_enc_round_ctrl_pkg;

    localparam int AES_W = 128;

    // Byte n of a block occupies bits 8n..8n+7; bytes are column-major.
    typedef logic [0:AES_W-1] block_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // S-box as GF(2^8) inverse (a^254, which maps 0 to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic block_t sub_bytes(input block_t s);
        block_t r;
        for (int n = 0; n < 16; n++) r[8*n +: 8] = sbox(s[8*n +: 8]);
        return r;
    endfunction

    // Row r of the state is rotated left by r columns.
    function automatic block_t shift_row(input block_t s);
        block_t r;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[8*(w + 4*c) +: 8] = s[8*(w + 4*((c + w) % 4)) +: 8];
        return r;
    endfunction

    function automatic block_t mix_columns(input block_t s);
        block_t     r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[8*(4*c)     +: 8];
            a1 = s[8*(4*c + 1) +: 8];
            a2 = s[8*(4*c + 2) +: 8];
            a3 = s[8*(4*c + 3) +: 8];
            r[8*(4*c)     +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[8*(4*c + 1) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[8*(4*c + 2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[8*(4*c + 3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes128_key_step.sv
// One AES-128 key-schedule step: derives the next round key from the current
// one and the round constant.
module aes128_key_step
    import aes128_enc_round_ctrl_pkg::*;
(
    input  logic [0:AES_W-1] rk,
    input  logic [7:0]       rcon_byte,
    output logic [0:AES_W-1] rk_next
);

    logic [0:31] w0, w1, w2, w3;
    logic [0:31] t, n0, n1, n2, n3;

    assign w0 = rk[0  +: 32];
    assign w1 = rk[32 +: 32];
    assign w2 = rk[64 +: 32];
    assign w3 = rk[96 +: 32];

    // SubWord(RotWord(w3)) with the round constant folded into byte 0.
    assign t = {sbox(w3[8  +: 8]) ^ rcon_byte,
                sbox(w3[16 +: 8]),
                sbox(w3[24 +: 8]),
                sbox(w3[0  +: 8])};

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign rk_next = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_enc_round_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, on-the-fly key schedule,
// valid/ready on both the plaintext and ciphertext sides.
module aes128_enc_round_ctrl
    import aes128_enc_round_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:AES_W-1] in_text,
    input  logic [0:AES_W-1] in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:AES_W-1] out_text,
    output logic             busy,
    output logic [3:0]       round_idx
);

    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 10) begin : g_bad_rounds
        $error("aes128_enc_round_ctrl: NUM_ROUNDS must be 1..10");
    end

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    state_t     state, state_nxt;
    block_t     st, rk, rk_n, sr, mc, round_out;
    logic [3:0] rnd;
    logic [7:0] rcon_byte;
    logic       accept, last_round;

    assign in_ready   = (state == IDLE) || (state == DONE && out_ready);
    assign accept     = in_valid && in_ready;
    assign last_round = (rnd == LAST_RND);
    assign busy       = (state == ROUND);
    assign round_idx  = (state == ROUND) ? rnd : 4'd0;
    assign rcon_byte  = rcon(rnd);

    aes128_key_step u_key_step (
        .rk        (rk),
        .rcon_byte (rcon_byte),
        .rk_next   (rk_n)
    );

    // The final round skips MixColumns.
    assign sr        = shift_row(sub_bytes(st));
    assign mc        = mix_columns(sr);
    assign round_out = (last_round ? sr : mc) ^ rk_n;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ROUND;
            ROUND:   if (last_round) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = in_valid ? ROUND : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= '0;
            rk        <= '0;
            rnd       <= 4'd0;
            out_text  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (state == ROUND) begin
                rk <= rk_n;
                if (last_round) begin
                    out_text  <= round_out;
                    out_valid <= 1'b1;
                end else begin
                    st  <= round_out;
                    rnd <= rnd + 4'd1;
                end
            end
            if (state == DONE && out_ready) out_valid <= 1'b0;
            // A retiring DONE may load the next block on the same edge.
            if (accept) begin
                st  <= in_text ^ in_key;
                rk  <= in_key;
                rnd <= 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_aes128_enc_round_ctrl.sv
// Bench for aes128_enc_round_ctrl: known-answer and random vectors against a
// byte-array AES model, plus backpressure, back-to-back, reset and 1-round cases.
module tb_aes128_enc_round_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [0:127] in_text, in_key, out_text;
    logic [3:0]   round_idx;

    logic         in_valid_1, in_ready_1, out_valid_1, out_ready_1, busy_1;
    logic [0:127] in_text_1, in_key_1, out_text_1;
    logic [3:0]   round_idx_1;

    aes128_enc_round_ctrl #(.NUM_ROUNDS(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_text(in_text), .in_key(in_key), .out_valid(out_valid),
        .out_ready(out_ready), .out_text(out_text), .busy(busy), .round_idx(round_idx)
    );

    aes128_enc_round_ctrl #(.NUM_ROUNDS(1)) dut_1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_1), .in_ready(in_ready_1),
        .in_text(in_text_1), .in_key(in_key_1), .out_valid(out_valid_1),
        .out_ready(out_ready_1), .out_text(out_text_1), .busy(busy_1), .round_idx(round_idx_1)
    );

    int checks   = 0;
    int failures = 0;
    int xfers    = 0;
    int accepts  = 0;

    always @(posedge clk) begin
        if (out_valid && out_ready) xfers <= xfers + 1;
        if (in_valid && in_ready) accepts <= accepts + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [7:0] sb [256];

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, c, s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[x] = s;
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] pt, input logic [127:0] key, input int nr);
        logic [7:0]   k [176];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   tmp [4];
        logic [7:0]   a [4];
        logic [7:0]   rc, t0;
        logic [127:0] res;
        for (int n = 0; n < 16; n++) begin
            k[n] = key[127-8*n -: 8];
            s[n] = pt[127-8*n -: 8] ^ k[n];
        end
        rc = 8'h01;
        for (int i = 4; i < 4*(nr+1); i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = k[4*(i-1)+j];
            if (i % 4 == 0) begin
                t0     = tmp[0];
                tmp[0] = sb[tmp[1]] ^ rc;
                tmp[1] = sb[tmp[2]];
                tmp[2] = sb[tmp[3]];
                tmp[3] = sb[t0];
                rc     = gm(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) k[4*i+j] = k[4*(i-4)+j] ^ tmp[j];
        end
        for (int r = 1; r <= nr; r++) begin
            for (int n = 0; n < 16; n++) t[n] = sb[s[n]];
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    s[row+4*col] = t[row+4*((col+row)%4)];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) a[j] = s[4*c+j];
                    s[4*c]   = gm(a[0], 8'h02) ^ gm(a[1], 8'h03) ^ a[2] ^ a[3];
                    s[4*c+1] = a[0] ^ gm(a[1], 8'h02) ^ gm(a[2], 8'h03) ^ a[3];
                    s[4*c+2] = a[0] ^ a[1] ^ gm(a[2], 8'h02) ^ gm(a[3], 8'h03);
                    s[4*c+3] = gm(a[0], 8'h03) ^ a[1] ^ a[2] ^ gm(a[3], 8'h02);
                end
            end
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ k[16*r+n];
        end
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_out(output int n, output bit seq_ok);
        n      = 0;
        seq_ok = 1'b1;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
            if (!busy || in_ready || round_idx != 4'(n + 1)) seq_ok = 1'b0;
        end
    endtask

    task automatic run_block(input logic [127:0] key, input logic [127:0] pt,
                             input logic [127:0] ct, input int hold, input string tag);
        int           n, x0;
        bit           seq_ok, stable;
        logic [127:0] snap;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_text   = pt;
        in_key    = key;
        chk({tag, ".in_ready"}, 128'(in_ready), 128'(1));
        @(negedge clk);
        in_valid = 1'b0;
        in_text  = rand128();
        in_key   = rand128();
        chk({tag, ".round1"}, 128'({busy, round_idx}), 128'({1'b1, 4'd1}));
        wait_out(n, seq_ok);
        chk({tag, ".latency"}, 128'(n), 128'(10));
        chk({tag, ".round_seq"}, 128'(seq_ok), 128'(1));
        chk({tag, ".done_flags"}, 128'({busy, round_idx}), 128'(0));
        chk({tag, ".out_text"}, out_text, ct);
        snap   = out_text;
        x0     = xfers;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!out_valid || out_text !== snap || in_ready) stable = 1'b0;
        end
        if (hold > 0) chk({tag, ".hold_stable"}, 128'(stable), 128'(1));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".retired"}, 128'({out_valid, in_ready}), 128'({1'b0, 1'b1}));
        chk({tag, ".xfers"}, 128'(xfers - x0), 128'(1));
    endtask

    task automatic run_small(input logic [127:0] key, input logic [127:0] pt, input string tag);
        int n;
        @(negedge clk);
        in_valid_1 = 1'b1;
        in_text_1  = pt;
        in_key_1   = key;
        chk({tag, ".in_ready"}, 128'(in_ready_1), 128'(1));
        @(negedge clk);
        in_valid_1 = 1'b0;
        chk({tag, ".round1"}, 128'({busy_1, round_idx_1}), 128'({1'b1, 4'd1}));
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (out_valid_1) break;
        end
        chk({tag, ".latency"}, 128'(n), 128'(1));
        chk({tag, ".out_text"}, out_text_1, model(pt, key, 1));
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           hold;
    } vec_t;

    vec_t tbl [10];

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

    initial begin
        int  n, a0, x0;
        bit  seq_ok;

        build_sbox();
        tbl[0] = '{KEY_C1, PT_C1, CT_C1, 0};
        tbl[1] = '{KEY_B, PT_B, CT_B, 2};
        for (int i = 2; i < 10; i++) begin
            tbl[i].key  = rand128();
            tbl[i].pt   = rand128();
            tbl[i].ct   = model(tbl[i].pt, tbl[i].key, 10);
            tbl[i].hold = int'($urandom_range(0, 3));
        end

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; in_text = '0; in_key = '0;
        in_valid_1 = 1'b0; out_ready_1 = 1'b1; in_text_1 = '0; in_key_1 = '0;
        repeat (3) @(negedge clk);
        chk("reset.flags", 128'({out_valid, busy, round_idx, in_ready}), 128'({1'b0, 1'b0, 4'd0, 1'b1}));
        chk("reset.out_text", out_text, 128'(0));
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_block(tbl[i].key, tbl[i].pt, tbl[i].ct, tbl[i].hold, $sformatf("vec%0d", i));
        end

        run_block(KEY_C1, PT_C1, CT_C1, 20, "backpressure");

        // Back-to-back: B then C.1 with in_valid held and out_ready high.
        @(negedge clk);
        a0 = accepts;
        x0 = xfers;
        in_valid = 1'b1; in_text = PT_B; in_key = KEY_B; out_ready = 1'b1;
        @(negedge clk);
        in_text = PT_C1; in_key = KEY_C1;
        wait_out(n, seq_ok);
        chk("b2b.first_latency", 128'(n), 128'(10));
        chk("b2b.first_text", out_text, CT_B);
        chk("b2b.in_ready_done", 128'(in_ready), 128'(1));
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b.reloaded", 128'({out_valid, busy, round_idx}), 128'({1'b0, 1'b1, 4'd1}));
        chk("b2b.accepts", 128'(accepts - a0), 128'(2));
        wait_out(n, seq_ok);
        chk("b2b.second_latency", 128'(n), 128'(10));
        chk("b2b.second_text", out_text, CT_C1);
        @(negedge clk);
        out_ready = 1'b0;
        chk("b2b.xfers", 128'(xfers - x0), 128'(2));
        chk("b2b.idle", 128'({out_valid, in_ready}), 128'({1'b0, 1'b1}));

        // Reset in round 5 abandons the block.
        @(negedge clk);
        in_valid = 1'b1; in_text = PT_C1; in_key = KEY_C1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (round_idx != 4'd5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid.reached_round5", 128'(round_idx), 128'(5));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid.flags", 128'({out_valid, busy, in_ready, round_idx}), 128'({1'b0, 1'b0, 1'b1, 4'd0}));
        chk("rst_mid.out_text", out_text, 128'(0));
        run_block(KEY_C1, PT_C1, CT_C1, 1, "after_rst");

        run_small(128'(0), 128'(0), "n1_zero");
        for (int i = 0; i < 3; i++) run_small(rand128(), rand128(), $sformatf("n1_rand%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
